// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer_if
//  Description : Bundles the three streams around the ALU command issuer:
//                  cmd_*  valid/ready command stream into the issuer
//                  alu_*  registered operands/opcode out, Out/Carry back
//                  rsp_*  valid/ready tagged response stream out
//                Modport "slave" is the issuer's view. Modport "master" is
//                the surrounding fabric plus the ALU datapath.
//  Parameters  : TAG_W - tag width; must match the issuer's TAG_W.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 4
) ();
  // command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  // ALU operand/opcode interface
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [7:0]       alu_out;
  logic             alu_carry;
  // response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_out;
  logic             rsp_carry;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_carry,
    input  rsp_valid, rsp_out, rsp_carry, rsp_err, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_carry,
    output rsp_valid, rsp_out, rsp_carry, rsp_err, rsp_tag,
    input  rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Initiator for the 8-bit combinational ALU. Accepts one
//                command at a time, holds registered operands/opcode on the
//                ALU for SETTLE_CYC cycles, samples Out/Carry and pushes a
//                tagged response into a small circular response FIFO.
//                Divide/modulo by zero returns out=FF, carry=0, err=1.
//  Ports       : clk, rst_n (async, active low)
//                bus.slave : cmd_* in, alu_* out / Out,Carry in, rsp_* out
//                rsp_mismatch, mismatch_cnt : only with ALU_CHK_EN
//  Options     : `define ALU_CHK_EN adds a reference ALU model, a per-entry
//                mismatch flag and a saturating mismatch counter.
//  Parameters  : TAG_W, FIFO_DEPTH (power of two, >= 2), SETTLE_CYC (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  wire              clk,
  input  wire              rst_n,
  alu_cmd_issuer_if.slave  bus
`ifdef ALU_CHK_EN
  ,
  output logic             rsp_mismatch,
  output logic [7:0]       mismatch_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  // FIFO entry layout: {[mismatch], out[7:0], carry, err, tag}
  localparam int ERR_B   = TAG_W;
  localparam int CARRY_B = TAG_W + 1;
  localparam int OUT_LSB = TAG_W + 2;
`ifdef ALU_CHK_EN
  localparam int MIS_B   = TAG_W + 10;
  localparam int ENT_W   = TAG_W + 11;
`else
  localparam int ENT_W   = TAG_W + 10;
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]       state_q,  state_d;
  logic [7:0]       alu_a_q,  alu_a_d;
  logic [7:0]       alu_b_q,  alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] tag_q,    tag_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];

  logic             cmd_ready;
  logic             push;
  logic             accept;
  logic             pop;
  logic             zero_div;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      tag_q    <= '0;
      settle_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      tag_q    <= tag_d;
      settle_q <= settle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // ----------------------------------------------------------- FSM outputs
  // Only one command is ever in flight, and a new one is taken only when the
  // FIFO has room, so the push at the end of DRIVE can never overflow.
  always_comb begin
    cmd_ready = 1'b0;
    push      = 1'b0;
    case (state_q)
      ST_IDLE:  cmd_ready = (count_q < DEPTH_C);
      ST_DRIVE: push      = (settle_q == '0);
      default:  ;
    endcase
  end

  assign accept   = bus.cmd_valid & cmd_ready;
  assign pop      = bus.rsp_ready & (count_q != '0);
  assign zero_div = ((alu_op_q == OP_DIV) || (alu_op_q == OP_MOD)) && (alu_b_q == 8'd0);

  // Zero-divisor entries ignore whatever the ALU produced.
  assign push_entry[TAG_W-1:0]        = tag_q;
  assign push_entry[ERR_B]            = zero_div;
  assign push_entry[CARRY_B]          = zero_div ? 1'b0  : bus.alu_carry;
  assign push_entry[OUT_LSB+7:OUT_LSB] = zero_div ? 8'hFF : bus.alu_out;

`ifdef ALU_CHK_EN
  logic [7:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [8:0] ref_res;
  logic       mismatch;

  // Reference ALU: returns {carry, out}. Logical ops give 0/1.
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [8:0] r;
    r = '0;
    case (op)
      4'd0:  r      = {1'b0, a} + {1'b0, b};
      4'd1:  r[7:0] = a - b;
      4'd2:  r[7:0] = a * b;
      4'd3:  r[7:0] = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:  r[7:0] = (b == 8'd0) ? 8'd0 : a % b;
      4'd5:  r[0]   = (a != 8'd0) && (b != 8'd0);
      4'd6:  r[0]   = (a != 8'd0) || (b != 8'd0);
      4'd7:  r[0]   = (a == 8'd0);
      4'd8:  r[0]   = (a != 8'd0) ^ (b != 8'd0);
      4'd9:  r[7:0] = a & b;
      4'd10: r[7:0] = a | b;
      4'd11: r[7:0] = ~b;
      4'd12: r[7:0] = a >> 1;
      4'd13: r[7:0] = b << 1;
      4'd14: r      = {1'b0, a} + 9'd1;
      default: r[7:0] = b - 8'd1;
    endcase
    return r;
  endfunction

  assign ref_res           = ref_alu(alu_a_q, alu_b_q, alu_op_q);
  assign mismatch          = ~zero_div & (ref_res != {bus.alu_carry, bus.alu_out});
  assign push_entry[MIS_B] = mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch_cnt_q <= '0;
    else        mismatch_cnt_q <= mismatch_cnt_d;
  end

  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (push && mismatch && (mismatch_cnt_q != 8'hFF))
      mismatch_cnt_d = mismatch_cnt_q + 8'd1;
  end

  assign rsp_mismatch = head[MIS_B];
  assign mismatch_cnt = mismatch_cnt_q;
`endif

  // ------------------------------------------------------ next-state logic
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    tag_d    = tag_q;
    settle_d = settle_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          tag_d    = bus.cmd_tag;
          settle_d = SETTLE_LOAD;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_q != '0) settle_d = settle_q - SET_W'(1);
        else                state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign head          = mem_q[rd_ptr_q];
  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_out   = head[OUT_LSB+7:OUT_LSB];
  assign bus.rsp_carry = head[CARRY_B];
  assign bus.rsp_err   = head[ERR_B];
  assign bus.rsp_tag   = head[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_issuer
//  Description : Self-checking bench for alu_cmd_issuer. Provides a
//                behavioural ALU on the alu_* side, directed scenarios from
//                the test plan and a randomized run against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [7:0]       out;
    logic             carry;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   inject = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busy   = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();

`ifdef ALU_CHK_EN
  logic       rsp_mismatch;
  logic [7:0] mismatch_cnt;
`endif

  alu_cmd_issuer #(
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (DEPTH),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_CHK_EN
    ,
    .rsp_mismatch (rsp_mismatch),
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  // Behavioural ALU in plain integer arithmetic; returns {carry, out}.
  function automatic logic [8:0] tb_alu(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    int x, y, r;
    bit c;
    x = int'(a); y = int'(b); r = 0; c = 1'b0;
    case (op)
      4'd0:  begin r = x + y; c = (r > 255); end
      4'd1:  r = x - y + 256;
      4'd2:  r = x * y;
      4'd3:  r = (y == 0) ? 0 : x / y;
      4'd4:  r = (y == 0) ? 0 : x % y;
      4'd5:  r = (x != 0 && y != 0) ? 1 : 0;
      4'd6:  r = (x != 0 || y != 0) ? 1 : 0;
      4'd7:  r = (x == 0) ? 1 : 0;
      4'd8:  r = ((x != 0) != (y != 0)) ? 1 : 0;
      4'd9:  r = x & y;
      4'd10: r = x | y;
      4'd11: r = 255 - y;
      4'd12: r = x / 2;
      4'd13: r = y * 2;
      4'd14: begin r = x + 1; c = (r > 255); end
      default: r = y - 1 + 256;
    endcase
    return {c, 8'(r % 256)};
  endfunction

  function automatic rsp_t model_rsp(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] op, input logic [TAG_W-1:0] tag);
    rsp_t r;
    logic [8:0] v;
    v = tb_alu(a, b, op);
    r.tag = tag;
    if ((op == 4'd3 || op == 4'd4) && b == 8'd0) begin
      r.out = 8'hFF; r.carry = 1'b0; r.err = 1'b1;
    end else begin
      r.out = v[7:0]; r.carry = v[8]; r.err = 1'b0;
    end
    return r;
  endfunction

  function automatic rsp_t mk(input logic [7:0] o, input logic c, input logic e,
                              input logic [TAG_W-1:0] t);
    rsp_t r;
    r.out = o; r.carry = c; r.err = e; r.tag = t;
    return r;
  endfunction

  function automatic rsp_t head();
    return mk(bus.rsp_out, bus.rsp_carry, bus.rsp_err, bus.rsp_tag);
  endfunction

  // ALU stand-in; inject flips Out bit 0 on Xor only.
  logic [8:0] alu_res;
  always_comb begin
    alu_res       = tb_alu(bus.alu_a, bus.alu_b, bus.alu_op);
    bus.alu_out   = alu_res[7:0] ^ {7'd0, (inject && bus.alu_op == 4'd8)};
    bus.alu_carry = alu_res[8];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_op = '0; bus.cmd_tag = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    busy = 0;
  endtask

  // Offer one command; on acceptance push the supplied expected response.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input rsp_t e);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    if (ok) exp_q.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready never high for tag %0d", tag);
    end
  endtask

  // Wait for a response, compare with the oldest expected one, pop it.
  task automatic pop_check(input string name);
    bit   seen;
    rsp_t e;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: rsp_valid=%b with %0d expected responses", name, bus.rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (head() !== e) begin
        errors++;
        $display("FAIL %s: got out=%h carry=%b err=%b tag=%h, want out=%h carry=%b err=%b tag=%h",
                 name, bus.rsp_out, bus.rsp_carry, bus.rsp_err, bus.rsp_tag,
                 e.out, e.carry, e.err, e.tag);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b, want 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_out, bus.rsp_carry, bus.rsp_err, bus.rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_values: alu_a=%h alu_b=%h alu_op=%h rsp_out=%h carry=%b err=%b tag=%h, want all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp_out, bus.rsp_carry, bus.rsp_err, bus.rsp_tag);
    end
  endtask

  task automatic test_add_latency();
    send(8'd200, 8'd100, 4'd0, 4'd3, mk(8'd44, 1'b1, 1'b0, 4'd3));
    checks++;
    if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b0, 8'd200, 8'd100, 4'd0}) begin
      errors++;
      $display("FAIL add_accept: rsp_valid=%b alu_a=%0d alu_b=%0d alu_op=%0d, want 0 200 100 0",
               bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: rsp_valid=%b one edge after accept, want 1", bus.rsp_valid);
    end
    pop_check("add_200_100");
  endtask

  task automatic test_div_zero();
    send(8'd7, 8'd0, 4'd3, 4'd5, mk(8'hFF, 1'b0, 1'b1, 4'd5));
    pop_check("div_by_zero");
    send(8'd9, 8'd4, 4'd4, 4'd6, mk(8'd1, 1'b0, 1'b0, 4'd6));
    pop_check("mod_9_4");
  endtask

  task automatic test_fifo_full();
    logic [7:0] a [6];
    logic [7:0] b [6];
    logic [3:0] op [6];
    int acc;
    rsp_t e;
    for (int k = 0; k < 6; k++) begin
      a[k] = 8'($urandom); b[k] = 8'($urandom_range(1, 255)); op[k] = 4'($urandom);
    end
    acc = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (acc < 6) begin
        bus.cmd_valid = 1'b1; bus.cmd_a = a[acc]; bus.cmd_b = b[acc];
        bus.cmd_op = op[acc]; bus.cmd_tag = TAG_W'(acc + 1);
      end else bus.cmd_valid = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back(model_rsp(a[acc], b[acc], op[acc], TAG_W'(acc + 1)));
        acc++;
      end
      step();
    end
    checks++;
    if (acc != 4 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_accept: accepted=%0d cmd_ready=%b, want 4 0", acc, bus.cmd_ready);
    end
    // single pop of the head, 5th command still offered
    e = exp_q.pop_front();
    checks++;
    if (head() !== e) begin
      errors++;
      $display("FAIL full_head: got tag=%h out=%h, want tag=%h out=%h", bus.rsp_tag, bus.rsp_out, e.tag, e.out);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_after_pop: cmd_ready=%b, want 1", bus.cmd_ready);
    end
    if (bus.cmd_ready) exp_q.push_back(model_rsp(a[4], b[4], op[4], TAG_W'(5)));
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) pop_check("full_drain");
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: rsp_valid=%b after drain, want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_push_pop_full();
    rsp_t e;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] a, b;
      logic [3:0] op;
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
      send(a, b, op, TAG_W'(k + 1), model_rsp(a, b, op, TAG_W'(k + 1)));
    end
    send(8'd255, 8'd0, 4'd14, 4'd4, mk(8'd0, 1'b1, 1'b0, 4'd4));
    // now in DRIVE with 3 entries: push and pop land on the same edge
    e = exp_q.pop_front();
    checks++;
    if (head() !== e) begin
      errors++;
      $display("FAIL pushpop_head: got tag=%h out=%h, want tag=%h out=%h", bus.rsp_tag, bus.rsp_out, e.tag, e.out);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b11) begin
      errors++;
      $display("FAIL pushpop_count3: cmd_ready=%b rsp_valid=%b, want 1 1", bus.cmd_ready, bus.rsp_valid);
    end
    for (int k = 0; k < 3; k++) pop_check("pushpop_drain");
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_empty: rsp_valid=%b after 3 pops, want 0", bus.rsp_valid);
    end
  endtask

  // One cycle of the randomized run against the queue model. busy counts
  // edges until the in-flight command lands in the FIFO.
  task automatic rand_cycle(input bit allow_cmd, input bit drain);
    int   fifo_n;
    bit   exp_ready, acc, pp;
    rsp_t cur;
    if (allow_cmd && !bus.cmd_valid && ($urandom_range(0, 1) == 1)) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 8'($urandom);
      bus.cmd_b     = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      bus.cmd_op    = 4'($urandom);
      bus.cmd_tag   = TAG_W'($urandom);
    end
    bus.rsp_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
    fifo_n    = exp_q.size() - ((busy > 0) ? 1 : 0);
    exp_ready = (busy == 0) && (fifo_n < DEPTH);
    checks++;
    if (bus.cmd_ready !== exp_ready || bus.rsp_valid !== (fifo_n > 0)) begin
      errors++;
      $display("FAIL rand_flow: cmd_ready=%b rsp_valid=%b, want %b %b", bus.cmd_ready, bus.rsp_valid,
               exp_ready, (fifo_n > 0));
    end
    if (fifo_n > 0) begin
      checks++;
      if (head() !== exp_q[0]) begin
        errors++;
        $display("FAIL rand_head: got out=%h carry=%b err=%b tag=%h, want out=%h carry=%b err=%b tag=%h",
                 bus.rsp_out, bus.rsp_carry, bus.rsp_err, bus.rsp_tag,
                 exp_q[0].out, exp_q[0].carry, exp_q[0].err, exp_q[0].tag);
      end
    end
    acc = bus.cmd_valid && exp_ready;
    pp  = (fifo_n > 0) && bus.rsp_ready;
    cur = model_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag);
    step();
    if (pp) void'(exp_q.pop_front());
    if (busy > 0) busy--;
    if (acc) begin
      exp_q.push_back(cur);
      busy = SETTLE;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    busy = 0;
    for (int c = 0; c < 400; c++) rand_cycle(1'b1, 1'b0);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 20; c++) rand_cycle(1'b0, 1'b1);
    bus.rsp_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: %0d responses outstanding, rsp_valid=%b, want 0 0", exp_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    send(8'd11, 8'd22, 4'd0, 4'd1, model_rsp(8'd11, 8'd22, 4'd0, 4'd1));
    send(8'd33, 8'd3, 4'd2, 4'd2, model_rsp(8'd33, 8'd3, 4'd2, 4'd2));
    send(8'd44, 8'd5, 4'd9, 4'd3, model_rsp(8'd44, 8'd5, 4'd9, 4'd3));
    // third command is in DRIVE with two entries queued
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: rsp_valid=%b alu_a=%h alu_b=%h alu_op=%h, want all 0",
               bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: rsp_valid=%b after release, want 0", bus.rsp_valid);
    end
    send(8'd5, 8'd9, 4'd1, 4'd7, mk(8'd252, 1'b0, 1'b0, 4'd7));
    pop_check("sub_after_reset");
  endtask

`ifdef ALU_CHK_EN
  task automatic test_chk();
    do_reset();
    inject = 1'b1;
    send(8'hF0, 8'h0F, 4'd8, 4'd9, mk(8'd1, 1'b0, 1'b0, 4'd9));
    step();
    checks++;
    if ({bus.rsp_valid, rsp_mismatch, mismatch_cnt} !== {2'b11, 8'd1}) begin
      errors++;
      $display("FAIL chk_flag: rsp_valid=%b rsp_mismatch=%b mismatch_cnt=%0d, want 1 1 1",
               bus.rsp_valid, rsp_mismatch, mismatch_cnt);
    end
    pop_check("chk_xor");
    inject = 1'b0;
    send(8'd1, 8'd2, 4'd0, 4'd10, mk(8'd3, 1'b0, 1'b0, 4'd10));
    step();
    checks++;
    if ({bus.rsp_valid, rsp_mismatch, mismatch_cnt} !== {2'b10, 8'd1}) begin
      errors++;
      $display("FAIL chk_clean: rsp_valid=%b rsp_mismatch=%b mismatch_cnt=%0d, want 1 0 1",
               bus.rsp_valid, rsp_mismatch, mismatch_cnt);
    end
    pop_check("chk_add");
  endtask
`endif

  initial begin
    test_reset();
    test_add_latency();
    test_div_zero();
    test_fifo_full();
    test_push_pop_full();
    test_random();
    test_reset_mid();
`ifdef ALU_CHK_EN
    test_chk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
